// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider / enable generator.
// Optional align input is compiled in when CLKDIV_ALIGN_EN is defined.
module clk_div_prog #(
  parameter int NCH     = 4,
  parameter int W       = 16,
  parameter int DEF_DIV = 8,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_in,
  input  logic           rst,
  // wr_en is a strobe with no ready: every write is accepted on the edge it is presented.
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [W-1:0]   wr_div,
`ifdef CLKDIV_ALIGN_EN
  input  logic           align,
`endif
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] dbg_run_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] DEF_EFF = (DEF_DIV == 1) ? W'(2) : W'(DEF_DIV);
  localparam logic         RST_RUN = (DEF_EFF != '0);
  localparam logic [W-1:0] RST_CNT = RST_RUN ? (DEF_EFF - ONE) : '0;

  logic          align_w;
  logic [W-1:0]  wval;

`ifdef CLKDIV_ALIGN_EN
  assign align_w = align;
`else
  assign align_w = 1'b0;
`endif

  // A divisor of 1 cannot make a square wave, so it is stored as 2.
  assign wval = (wr_div == ONE) ? W'(2) : wr_div;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e       state_q, state_d;
    logic [W-1:0] div_q, div_d, cnt_q, cnt_d, pend_q, pend_d;
    logic         pend_v_q, pend_v_d, clk_q, clk_d, tick_q, tick_d;
    logic         hit, wrap, load_en, consume;
    logic [W-1:0] load_val;
    logic [W:0]   half;

    assign hit  = wr_en && (wr_ch == CHW'(g));
    assign wrap = (state_q == ST_RUN) && (cnt_q == div_q - ONE);
    assign half = ({1'b0, div_q} + (W+1)'(1)) >> 1;

    always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      load_en  = 1'b0;
      consume  = 1'b0;
      load_val = hit ? wval : pend_q;

      if (align_w) begin
        load_en = 1'b1;
        consume = 1'b1;
        if (!hit && !pend_v_q) load_val = div_q;
      end else if (state_q == ST_RUN) begin
        if (wrap && (hit || pend_v_q)) begin
          load_en = 1'b1;
          consume = 1'b1;
        end else begin
          cnt_d  = wrap ? '0 : cnt_q + ONE;
          clk_d  = ({1'b0, cnt_d} < half);
          tick_d = (cnt_d == '0);
        end
      end else if (pend_v_q) begin
        // Idle channel: the pending value lands one edge after it was written.
        load_en  = 1'b1;
        load_val = pend_q;
      end

      if (load_en) begin
        div_d    = load_val;
        cnt_d    = '0;
        pend_v_d = 1'b0;
        if (load_val == '0) begin
          state_d = ST_IDLE;
          clk_d   = 1'b0;
          tick_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end

      if (hit && !consume) begin
        pend_d   = wval;
        pend_v_d = 1'b1;
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst) begin
        state_q  <= RST_RUN ? ST_RUN : ST_IDLE;
        div_q    <= DEF_EFF;
        cnt_q    <= RST_CNT;
        pend_q   <= '0;
        pend_v_q <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        div_q    <= div_d;
        cnt_q    <= cnt_d;
        pend_q   <= pend_d;
        pend_v_q <= pend_v_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign clk_out[g]   = clk_q;
    assign tick[g]      = tick_q;
    assign busy[g]      = pend_v_q;
    assign dbg_run_o[g] = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: period/duty/tick per channel, pending writes,
// disable/enable, coercion, invalid channel, reset, and align when compiled in.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_en3, align;
  logic [1:0] wr_ch;
  logic [15:0] wr_div;
  logic [3:0] clk_out, tick, busy, dbg_run;
  logic [2:0] clk_out3, tick3, busy3, dbg_run3;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc;
  int e_per[4], e_start[4];
  bit e_on[4], e_busy[4];
  bit e_rst;
  int e3_start;

  always #5 clk = ~clk;

  clk_div_prog #(.NCH(4), .W(16), .DEF_DIV(8)) u_dut (
    .clk_in(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef CLKDIV_ALIGN_EN
    .align(align),
`endif
    .clk_out(clk_out), .tick(tick), .busy(busy), .dbg_run_o(dbg_run)
  );

  // Three-channel copy: channel index 3 does not exist here.
  clk_div_prog #(.NCH(3), .W(16), .DEF_DIV(8)) u_dut3 (
    .clk_in(clk), .rst(rst), .wr_en(wr_en3), .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef CLKDIV_ALIGN_EN
    .align(align),
`endif
    .clk_out(clk_out3), .tick(tick3), .busy(busy3), .dbg_run_o(dbg_run3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic [3:0] ec, et, eb, er;
    logic [2:0] ec3, et3;
    for (int i = 0; i < 4; i++) begin
      int ph;
      ec[i] = 1'b0;
      et[i] = 1'b0;
      eb[i] = e_rst ? 1'b0 : e_busy[i];
      er[i] = e_rst ? 1'b1 : e_on[i];
      if (!e_rst && e_on[i]) begin
        ph    = (cyc - e_start[i]) % e_per[i];
        ec[i] = (ph < (e_per[i] + 1) / 2);
        et[i] = (ph == 0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      int ph;
      ec3[i] = 1'b0;
      et3[i] = 1'b0;
      if (!e_rst) begin
        ph     = (cyc - e3_start) % 8;
        ec3[i] = (ph < 4);
        et3[i] = (ph == 0);
      end
    end
    check("clk_out", 32'(clk_out), 32'(ec));
    check("tick", 32'(tick), 32'(et));
    check("busy", 32'(busy), 32'(eb));
    check("run", 32'(dbg_run), 32'(er));
    check("clk_out3", 32'(clk_out3), 32'(ec3));
    check("tick3", 32'(tick3), 32'(et3));
    check("busy3", 32'(busy3), 32'(3'b000));
  endtask

  task automatic step();
    @(negedge clk);
    cyc = cyc + 1;
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = d;
  endtask

  task automatic all_default(input int start);
    for (int i = 0; i < 4; i++) begin
      e_per[i]   = 8;
      e_start[i] = start;
      e_on[i]    = 1'b1;
      e_busy[i]  = 1'b0;
    end
    e3_start = start;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_en3 = 1'b0; align = 1'b0; wr_ch = '0; wr_div = '0;
    repeat (3) @(negedge clk);
    cyc = -1;
    e_rst = 1'b1;
    all_default(0);
    check_cycle();

    // T1: reset divisor 8 on every channel, first tick on the first edge.
    rst = 1'b0; e_rst = 1'b0;
    run(40);
    run(2);

    // T2: ch1 -> 5 mid-period, applied at the wrap edge 48.
    wr(2'd1, 16'd5); e_busy[1] = 1'b1;
    step();
    wr_en = 1'b0;
    run(5);
    e_busy[1] = 1'b0; e_per[1] = 5; e_start[1] = 48;
    run(15);

    // T3: ch2 disabled at wrap 64, then re-enabled with 3 one edge after the write.
    wr(2'd2, 16'd0); e_busy[2] = 1'b1;
    step();
    wr_en = 1'b0;
    e_busy[2] = 1'b0; e_on[2] = 1'b0;
    run(6);
    wr(2'd2, 16'd3); e_busy[2] = 1'b1;
    step();
    wr_en = 1'b0;
    e_busy[2] = 1'b0; e_on[2] = 1'b1; e_per[2] = 3; e_start[2] = 71;
    run(10);

    // T4: divisor 1 coerced to 2 on ch3.
    wr(2'd3, 16'd1); e_busy[3] = 1'b1;
    step();
    wr_en = 1'b0;
    run(6);
    e_busy[3] = 1'b0; e_per[3] = 2; e_start[3] = 88;
    run(8);

    // Two writes before the wrap: the last one (10) wins at edge 98.
    wr(2'd1, 16'd6); e_busy[1] = 1'b1;
    step();
    wr(2'd1, 16'd10);
    step();
    wr_en = 1'b0;
    e_busy[1] = 1'b0; e_per[1] = 10; e_start[1] = 98;
    run(13);

    // Channel 3 is out of range for the three-channel copy; same write is valid on u_dut.
    wr(2'd3, 16'd2); wr_en3 = 1'b1; e_busy[3] = 1'b1;
    step();
    wr_en = 1'b0; wr_en3 = 1'b0;
    e_busy[3] = 1'b0; e_start[3] = 112;
    run(8);

    // A write landing on the wrap edge takes effect immediately (ch0 -> 4 at edge 120).
    wr(2'd0, 16'd4); e_per[0] = 4; e_start[0] = 120;
    step();
    wr_en = 1'b0;
    run(8);

    // T5: reset mid-period with a pending write on ch1 drops the write.
    wr(2'd1, 16'd7); e_busy[1] = 1'b1;
    step();
    wr_en = 1'b0;
    run(1);
    rst = 1'b1; e_rst = 1'b1;
    step();
    rst = 1'b0; e_rst = 1'b0;
    all_default(132);
    run(18);

`ifdef CLKDIV_ALIGN_EN
    // T6: D={8,5,3,0} then align; ch3's write of 0 arrives on the align edge itself.
    run(1);
    wr(2'd1, 16'd5); e_busy[1] = 1'b1;
    step();
    wr(2'd2, 16'd3); e_busy[2] = 1'b1;
    step();
    wr(2'd3, 16'd0); align = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e_busy[i]  = 1'b0;
      e_start[i] = 153;
    end
    e_per[0] = 8; e_per[1] = 5; e_per[2] = 3; e_on[3] = 1'b0; e3_start = 153;
    step();
    wr_en = 1'b0; align = 1'b0;
    run(12);
`else
    run(16);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
